// File: rtl/fb_port_arbiter_if.sv
// Requester-side handshake for one framebuffer port client (host or engine).
// master = requester FSM, slave = arbiter.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic              wdata;
    logic              lock;
    logic              gnt;
    logic              rvalid;

    modport master (
        output req, we, addr, wdata, lock,
        input  gnt, rvalid
    );

    modport slave (
        input  req, we, addr, wdata, lock,
        output gnt, rvalid
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single framebuffer RAM port shared by host and drawing engine: host priority,
// starvation bound for the engine, and a lock for atomic multi-cycle sequences.
module fb_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    fb_port_arbiter_if.slave  host,
    fb_port_arbiter_if.slave  eng,
    output logic              rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    input  logic              ram_rdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_HOST = 2'd1,
        OWN_ENG  = 2'd2
    } own_e;

    typedef struct packed {
        logic              req;
        logic              we;
        logic              wdata;
        logic              lock;
        logic [ADDR_W-1:0] addr;
    } req_t;

    localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

    own_e              owner_q, owner_d, eff_owner;
    own_e              rd_tag_q, rd_tag_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] last_addr_q;
    req_t              h_r, e_r;
    logic              h_gnt, e_gnt, any_gnt;
    logic              sel_we, sel_wdata;
    logic [ADDR_W-1:0] sel_addr;

    assign h_r = {host.req, host.we, host.wdata, host.lock, host.addr};
    assign e_r = {eng.req,  eng.we,  eng.wdata,  eng.lock,  eng.addr};

    // A lock holder that stops requesting forfeits the lock in the same cycle.
    always_comb begin
        eff_owner = owner_q;
        if (owner_q == OWN_HOST && !h_r.req) eff_owner = OWN_NONE;
        if (owner_q == OWN_ENG  && !e_r.req) eff_owner = OWN_NONE;
    end

    always_comb begin
        h_gnt = 1'b0;
        e_gnt = 1'b0;
        if (!rst) begin
            case (eff_owner)
                OWN_HOST: h_gnt = 1'b1;
                OWN_ENG:  e_gnt = 1'b1;
                default: begin
                    if (e_r.req && (starve_q == STARVE_MAX || !h_r.req))
                        e_gnt = 1'b1;
                    else if (h_r.req)
                        h_gnt = 1'b1;
                end
            endcase
        end
    end

    assign any_gnt   = h_gnt | e_gnt;
    assign sel_we    = e_gnt ? e_r.we    : h_r.we;
    assign sel_wdata = e_gnt ? e_r.wdata : h_r.wdata;
    assign sel_addr  = e_gnt ? e_r.addr  : h_r.addr;

    // Idle cycles park the address on the last access so the RAM never sees X.
    assign ram_we    = any_gnt & sel_we;
    assign ram_wdata = any_gnt & sel_wdata;
    assign ram_addr  = any_gnt ? sel_addr : last_addr_q;

    always_comb begin
        owner_d = OWN_NONE;
        if (h_gnt && h_r.lock)      owner_d = OWN_HOST;
        else if (e_gnt && e_r.lock) owner_d = OWN_ENG;

        starve_d = '0;
        if (e_r.req && !e_gnt)
            starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : 4'(starve_q + 4'd1);

        rd_tag_d = OWN_NONE;
        if (h_gnt && !h_r.we)      rd_tag_d = OWN_HOST;
        else if (e_gnt && !e_r.we) rd_tag_d = OWN_ENG;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= OWN_NONE;
            starve_q    <= '0;
            rd_tag_q    <= OWN_NONE;
            last_addr_q <= '0;
        end else begin
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            rd_tag_q    <= rd_tag_d;
            if (any_gnt) last_addr_q <= sel_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(h_gnt && e_gnt));
    end

    // RAM output is registered, so the tag from the grant cycle qualifies it now.
    assign host.gnt    = h_gnt;
    assign eng.gnt     = e_gnt;
    assign host.rvalid = !rst && (rd_tag_q == OWN_HOST);
    assign eng.rvalid  = !rst && (rd_tag_q == OWN_ENG);
    assign rdata       = ram_rdata;
    assign owner       = owner_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: behavioural RAM, per-cycle vectors, read scoreboard.
module tb_fb_port_arbiter;
    localparam int AW = 16;

    typedef struct {
        bit          hreq, hwe, hlock, hwd;
        logic [15:0] haddr;
        bit          ereq, ewe, elock, ewd;
        logic [15:0] eaddr;
        bit          xh, xe;
        int          own;
        bit          r;
    } vec_t;

    typedef struct {
        int due;
        bit host;
        bit data;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_W(AW)) hif ();
    fb_port_arbiter_if #(.ADDR_W(AW)) eif ();

    logic          rdata, ram_we, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;
    logic [1:0]    owner;

    fb_port_arbiter #(.ADDR_W(AW), .MAX_STARVE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .host      (hif.slave),
        .eng       (eif.slave),
        .rdata     (rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .owner     (owner)
    );

    logic mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    logic [15:0]   last_a = '0;
    rd_t           sbq[$];
    vec_t          tbl[10];

    function automatic vec_t v(input bit hreq, hwe, hlock, input logic [15:0] haddr, input bit hwd,
                               input bit ereq, ewe, elock, input logic [15:0] eaddr, input bit ewd,
                               input bit xh, xe, input int own, input bit r = 1'b0);
        vec_t t;
        t.hreq = hreq; t.hwe = hwe; t.hlock = hlock; t.haddr = haddr; t.hwd = hwd;
        t.ereq = ereq; t.ewe = ewe; t.elock = elock; t.eaddr = eaddr; t.ewd = ewd;
        t.xh = xh; t.xe = xe; t.own = own; t.r = r;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drive one cycle at negedge, check combinational and registered outputs
    // just after, and queue the read return expected one cycle later.
    task automatic step(input vec_t t);
        rd_t e;
        bit  ehv, eev, ed;
        @(negedge clk);
        cyc++;
        rst = t.r;
        hif.req = t.hreq; hif.we = t.hwe; hif.lock = t.hlock; hif.addr = t.haddr; hif.wdata = t.hwd;
        eif.req = t.ereq; eif.we = t.ewe; eif.lock = t.elock; eif.addr = t.eaddr; eif.wdata = t.ewd;
        #1;
        chk("h_gnt", hif.gnt, t.xh);
        chk("e_gnt", eif.gnt, t.xe);
        chk("ram_we", ram_we, (t.xh & t.hwe) | (t.xe & t.ewe));
        if (t.xh) chk("ram_addr_h", ram_addr, t.haddr);
        else if (t.xe) chk("ram_addr_e", ram_addr, t.eaddr);
        else chk("ram_addr_hold", ram_addr, last_a);
        if (t.xh && t.hwe) chk("ram_wdata_h", ram_wdata, t.hwd);
        if (t.xe && t.ewe) chk("ram_wdata_e", ram_wdata, t.ewd);
        if (t.own >= 0) chk("owner", owner, t.own);

        ehv = 1'b0; eev = 1'b0; ed = 1'b0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (!t.r) begin
                ehv = e.host; eev = !e.host; ed = e.data;
            end
        end
        chk("h_rvalid", hif.rvalid, ehv);
        chk("e_rvalid", eif.rvalid, eev);
        if (ehv || eev) chk("rdata", rdata, ed);

        if (t.xh && !t.hwe) sbq.push_back('{cyc + 1, 1'b1, mem[t.haddr]});
        if (t.xe && !t.ewe) sbq.push_back('{cyc + 1, 1'b0, mem[t.eaddr]});
        if (t.r) last_a = '0;
        else if (t.xh) last_a = t.haddr;
        else if (t.xe) last_a = t.eaddr;
    endtask

    initial begin
        vec_t idle;
        hif.req = 0; hif.we = 0; hif.lock = 0; hif.addr = '0; hif.wdata = 0;
        eif.req = 0; eif.we = 0; eif.lock = 0; eif.addr = '0; eif.wdata = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 1'b0;
        mem[16'h0140] = 1'b1;
        mem[16'h0142] = 1'b1;
        idle = v(0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0, -1);

        // Reset holds everything off even with both requesting
        repeat (2) step(v(1,0,0,16'h0140,0, 1,0,0,16'h0142,0, 0,0, 0, 1'b1));

        // Host-only read
        step(v(1,0,0,16'h0140,0, 0,0,0,16'h0,0, 1,0, 0));
        step(idle);

        // Contention table: 4 host : 1 engine
        for (int i = 0; i < 10; i++)
            tbl[i] = v(1,0,0,16'h0140,0, 1,0,0,16'h0142,0, (i % 5) != 4, (i % 5) == 4, 0);
        for (int i = 0; i < 10; i++) step(tbl[i]);

        // Engine locked read-modify-write with host requesting throughout
        repeat (4) step(v(1,0,0,16'h0140,0, 1,0,1,16'h0010,0, 1,0, 0));
        step(v(1,0,0,16'h0140,0, 1,0,1,16'h0010,0, 0,1, 0));
        step(v(1,0,0,16'h0140,0, 1,1,0,16'h0010,1, 0,1, 2));
        step(v(1,0,0,16'h0010,0, 0,0,0,16'h0,0, 1,0, 0));

        // Same address from both: only the host write lands
        step(v(1,1,0,16'h0020,1, 1,1,0,16'h0020,0, 1,0, 0));
        step(v(1,0,0,16'h0020,0, 0,0,0,16'h0,0, 1,0, 0));
        step(idle);

        // Host lock is absolute; starved engine wins right after it ends
        for (int i = 0; i < 10; i++)
            step(v(1,0,1,16'h0140,0, 1,0,0,16'h0142,0, 1,0, (i == 0) ? 0 : 1));
        step(v(1,0,0,16'h0140,0, 1,0,0,16'h0142,0, 1,0, 1));
        step(v(1,0,0,16'h0140,0, 1,0,0,16'h0142,0, 0,1, 0));
        step(idle);

        // Engine lock released by dropping e_req
        step(v(0,0,0,16'h0,0, 1,0,1,16'h0142,0, 0,1, 0));
        step(v(1,0,0,16'h0140,0, 0,0,0,16'h0,0, 1,0, 2));
        step(v(0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0, 0));

        // Reset lands the cycle after a locked engine read
        step(v(0,0,0,16'h0,0, 1,0,1,16'h0142,0, 0,1, 0));
        step(v(1,0,0,16'h0140,0, 1,0,1,16'h0142,0, 0,0, -1, 1'b1));
        step(v(0,0,0,16'h0,0, 0,0,0,16'h0,0, 0,0, 0));
        step(v(1,0,0,16'h0140,0, 0,0,0,16'h0,0, 1,0, 0));
        step(idle);
        step(idle);

        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
